core_sequencer: RTL and testbench



---
 rtl/core_sequencer.sv | 130 +++++++++++++
 tb/tb_core_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Launch and shared-memory controller for the processor_a array: drives core status,
// round-robin arbitrates core data-memory writes onto one port, and tracks completion.
module core_sequencer #(
    parameter int NUM_CORES = 4,
    parameter int AW        = 16,
    parameter int DW        = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [NUM_CORES-1:0]    core_dm_en,
    input  logic [NUM_CORES*AW-1:0] core_ar_out,
    input  logic [NUM_CORES*DW-1:0] core_r2_out,
    input  logic [NUM_CORES-1:0]    core_end,
    output logic [2*NUM_CORES-1:0]  core_status,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            run_cycles
);
    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    localparam logic [1:0] ST_HOLD  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    logic [NUM_CORES-1:0] fin;
    logic [NUM_CORES-1:0] fin_nxt;
    logic [NUM_CORES-1:0] req;
    logic [NUM_CORES-1:0] grant;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        grant_idx;
    logic [PW-1:0]        rr_next;
    logic                 grant_vld;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign req     = core_dm_en & ~fin;
    assign fin_nxt = fin | core_end;

    // Round-robin scan starting at rr_ptr; first active requester wins.
    always_comb begin : arb
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int j = 0; j < NUM_CORES; j++) begin
            idx = int'(rr_ptr) + j;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (!grant_vld && req[PW'(idx)]) begin
                grant[PW'(idx)] = 1'b1;
                grant_idx       = PW'(idx);
                grant_vld       = 1'b1;
            end
        end
    end

    assign rr_next = (grant_idx == PW'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;

    // Losing requesters see stall in the same cycle so they keep their request stable.
    always_comb begin
        core_status = '0;
        if (state == S_RUN) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (!fin[i]) begin
                    core_status[2*i +: 2] = (req[i] && !grant[i]) ? ST_STALL : ST_RUN;
                end else begin
                    core_status[2*i +: 2] = ST_HOLD;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            fin        <= '0;
            rr_ptr     <= '0;
            run_cycles <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    run_cycles <= sat_inc16(run_cycles);
                    fin        <= fin_nxt;
                    mem_we     <= grant_vld;
                    if (grant_vld) begin
                        mem_addr  <= core_ar_out[grant_idx*AW +: AW];
                        mem_wdata <= core_r2_out[grant_idx*DW +: DW];
                        rr_ptr    <= rr_next;
                    end
                    // A core_end sampled on this edge counts toward completion.
                    if (&fin_nxt) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    mem_we <= 1'b0;
                    if (start) begin
                        state      <= S_RUN;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        fin        <= '0;
                        rr_ptr     <= '0;
                        run_cycles <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: expected memory writes are queued as stimulus is
// driven and popped by a write monitor; status/control outputs are checked inline.
module tb_core_sequencer;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [N-1:0]     dm_en;
    logic [N-1:0]     cend;
    logic [N*16-1:0]  ar;
    logic [N*16-1:0]  r2;
    logic [2*N-1:0]   status;
    logic             mem_we;
    logic [15:0]      mem_addr;
    logic [15:0]      mem_wdata;
    logic             busy;
    logic             done;
    logic [15:0]      run_cycles;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t exp_q[$];

    core_sequencer #(.NUM_CORES(N), .AW(16), .DW(16)) dut (
        .clock       (clk),
        .reset_n     (reset_n),
        .start       (start),
        .core_dm_en  (dm_en),
        .core_ar_out (ar),
        .core_r2_out (r2),
        .core_end    (cend),
        .core_status (status),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .done        (done),
        .run_cycles  (run_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_core(input int i, input logic [15:0] a, input logic [15:0] d);
        ar[i*16 +: 16] = a;
        r2[i*16 +: 16] = d;
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    // Write monitor: every memory write must match the next queued expectation.
    always @(negedge clk) begin
        wr_t w;
        if (reset_n === 1'b1 && mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write: observed addr %h data %h, expected no write",
                       mem_addr, mem_wdata);
            end else begin
                w = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(w.a));
                chk("wr_data", 32'(mem_wdata), 32'(w.d));
            end
        end
    end

    initial begin
        int end_cyc [N];
        logic [7:0] exp_st;

        end_cyc[0] = 12;
        end_cyc[1] = 5;
        end_cyc[2] = 20;
        end_cyc[3] = 9;

        reset_n = 1'b0;
        start   = 1'b0;
        dm_en   = '0;
        cend    = '0;
        ar      = '0;
        r2      = '0;

        // Reset and launch
        repeat (3) begin
            mid();
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_we", 32'(mem_we), 0);
            chk("rst_addr", 32'(mem_addr), 0);
            chk("rst_wdata", 32'(mem_wdata), 0);
            chk("rst_status", 32'(status), 0);
            chk("rst_cycles", 32'(run_cycles), 0);
        end
        next_cyc(); reset_n = 1'b1;
        mid();
        chk("idle_busy", 32'(busy), 0);
        next_cyc(); start = 1'b1;
        mid();
        chk("idle_status", 32'(status), 0);
        next_cyc(); start = 1'b0;
        mid();
        chk("launch_busy", 32'(busy), 1);
        chk("launch_status", 32'(status), 32'h55);
        chk("launch_cycles", 32'(run_cycles), 0);
        chk("launch_done", 32'(done), 0);

        // Single writer: core 2
        next_cyc(); dm_en = 4'b0100; set_core(2, 16'h0010, 16'h1234); push_wr(16'h0010, 16'h1234);
        mid();
        chk("single_status", 32'(status), 32'h55);
        next_cyc(); dm_en = 4'b0000;
        mid();
        chk("single_we", 32'(mem_we), 1);
        chk("single_status_after", 32'(status), 32'h55);

        // Core 3 alone wraps the pointer back to 0
        next_cyc(); dm_en = 4'b1000; set_core(3, 16'h0030, 16'hBEEF); push_wr(16'h0030, 16'hBEEF);
        mid();
        chk("c3_status", 32'(status), 32'h55);
        next_cyc(); dm_en = 4'b0000;
        mid();
        chk("c3_we", 32'(mem_we), 1);

        // Full contention: grants 0,1,2,3
        next_cyc();
        dm_en = 4'b1111;
        for (int i = 0; i < N; i++) begin
            set_core(i, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
            push_wr(16'h0100 + 16'(i), 16'hA000 + 16'(i));
        end
        for (int k = 0; k < N; k++) begin
            mid();
            exp_st = '0;
            for (int i = 0; i < N; i++) exp_st[2*i +: 2] = (i > k) ? 2'd2 : 2'd1;
            chk("contend_status", 32'(status), 32'(exp_st));
            if (k > 0) chk("contend_we", 32'(mem_we), 1);
            next_cyc();
            dm_en[k] = 1'b0;
        end
        mid();
        chk("contend_last_we", 32'(mem_we), 1);

        // Cores 0 and 3 together: pointer wrapped, core 0 first
        next_cyc(); dm_en = 4'b1001;
        set_core(0, 16'h0200, 16'hB000); set_core(3, 16'h0203, 16'hB003);
        push_wr(16'h0200, 16'hB000); push_wr(16'h0203, 16'hB003);
        mid();
        chk("pair_status", 32'(status), 32'h95);
        next_cyc(); dm_en = 4'b1000;
        mid();
        chk("pair_status2", 32'(status), 32'h55);
        chk("pair_we0", 32'(mem_we), 1);
        next_cyc(); dm_en = 4'b0000;
        mid();
        chk("pair_we3", 32'(mem_we), 1);
        next_cyc();
        mid();
        chk("pair_idle_we", 32'(mem_we), 0);
        chk("queue_empty_a", 32'(exp_q.size()), 0);

        // Finish this run
        next_cyc(); cend = 4'b1111;
        next_cyc(); cend = 4'b0000;
        mid();
        chk("fin_done", 32'(done), 1);
        chk("fin_busy", 32'(busy), 0);
        chk("fin_status", 32'(status), 0);

        // Staggered completion
        next_cyc(); start = 1'b1;
        next_cyc(); start = 1'b0;
        set_core(1, 16'h0F00, 16'h0F0F);
        for (int c = 1; c <= 24; c++) begin
            cend = '0;
            for (int i = 0; i < N; i++) if (end_cyc[i] == c) cend[i] = 1'b1;
            dm_en = (c == 15) ? 4'b0010 : 4'b0000;
            start = (c == 10);
            mid();
            if (c <= 20) begin
                exp_st = '0;
                for (int i = 0; i < N; i++) exp_st[2*i +: 2] = (end_cyc[i] < c) ? 2'd0 : 2'd1;
                chk("stag_status", 32'(status), 32'(exp_st));
                chk("stag_busy", 32'(busy), 1);
                chk("stag_cycles", 32'(run_cycles), 32'(c - 1));
            end else begin
                chk("stag_done", 32'(done), 1);
                chk("stag_busy_low", 32'(busy), 0);
                chk("stag_final_cycles", 32'(run_cycles), 20);
                chk("stag_status_done", 32'(status), 0);
            end
            if (c == 16) chk("stag_no_write", 32'(mem_we), 0);
            next_cyc();
        end
        cend = '0; dm_en = '0; start = 1'b0;

        // End with request: core 0
        next_cyc(); start = 1'b1;
        next_cyc(); start = 1'b0;
        dm_en = 4'b0001; cend = 4'b0001;
        set_core(0, 16'h0500, 16'h5555); push_wr(16'h0500, 16'h5555);
        mid();
        chk("endreq_status", 32'(status), 32'h55);
        next_cyc(); cend = 4'b0000; set_core(0, 16'h0501, 16'h6666);
        mid();
        chk("endreq_status2", 32'(status), 32'h54);
        chk("endreq_we", 32'(mem_we), 1);
        next_cyc();
        mid();
        chk("endreq_ignored", 32'(mem_we), 0);

        // Reset mid-run with requests pending
        next_cyc(); dm_en = 4'b1110;
        set_core(1, 16'h0601, 16'hC001); set_core(2, 16'h0602, 16'hC002); set_core(3, 16'h0603, 16'hC003);
        push_wr(16'h0601, 16'hC001);
        mid();
        chk("rstmid_status", 32'(status), 32'hA4);
        next_cyc(); dm_en = 4'b1100;
        mid();
        chk("rstmid_we_pre", 32'(mem_we), 1);
        chk("rstmid_status2", 32'(status), 32'h94);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_we", 32'(mem_we), 0);
        chk("rstmid_status0", 32'(status), 0);
        chk("rstmid_busy", 32'(busy), 0);
        next_cyc();
        mid();
        chk("rstmid_hold_we", 32'(mem_we), 0);
        chk("rstmid_cycles", 32'(run_cycles), 0);
        next_cyc(); reset_n = 1'b1;
        mid();
        chk("post_rst_status", 32'(status), 0);
        chk("post_rst_busy", 32'(busy), 0);
        next_cyc(); dm_en = 4'b0000;
        mid();
        chk("post_rst_idle", 32'(busy), 0);
        chk("post_rst_we", 32'(mem_we), 0);

        // Clean relaunch
        next_cyc(); start = 1'b1;
        next_cyc(); start = 1'b0;
        mid();
        chk("relaunch_busy", 32'(busy), 1);
        chk("relaunch_status", 32'(status), 32'h55);
        chk("relaunch_cycles", 32'(run_cycles), 0);
        next_cyc(); dm_en = 4'b1010;
        set_core(1, 16'h0701, 16'hD001); set_core(3, 16'h0703, 16'hD003);
        push_wr(16'h0701, 16'hD001); push_wr(16'h0703, 16'hD003);
        mid();
        chk("relaunch_cycles1", 32'(run_cycles), 1);
        chk("relaunch_pair_status", 32'(status), 32'h95);
        next_cyc(); dm_en = 4'b1000;
        mid();
        chk("relaunch_we1", 32'(mem_we), 1);
        next_cyc(); dm_en = 4'b0000;
        mid();
        chk("relaunch_we3", 32'(mem_we), 1);
        next_cyc();
        mid();
        chk("relaunch_idle_we", 32'(mem_we), 0);
        next_cyc(); cend = 4'b1111;
        next_cyc(); cend = 4'b0000;
        mid();
        chk("relaunch_done", 32'(done), 1);
        chk("relaunch_final_cycles", 32'(run_cycles), 6);
        chk("queue_empty_b", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
